line_refill_responder: RTL

- Synthesizable read-burst responder: the memory-side end of the instruction-cache refill interface.
- Accepts one line address per request (arvalid/arready) and returns LINE_WORDS data beats (rvalid/rready/rlast) from an internal synchronous word memory.
- Used as the refill memory in cache unit benches and FPGA smoke builds.
- Includes a preload write port so benches and boot logic can fill the memory.

---
 rtl/refill_pkg.sv | 17 +
 rtl/line_resp_sram.sv | 37 +++
 rtl/line_refill_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/refill_pkg.sv
// Shared refill-path definitions (responder and inst_cache refill logic):
// FSM encoding and default line/memory geometry.
package refill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } refill_state_e;

  localparam int DATA_W         = 32;
  localparam int DEF_LINE_WORDS = 8;
  localparam int DEF_MEM_WORDS  = 1024;
  localparam int LINE_OFF_W     = $clog2(DEF_LINE_WORDS);
  localparam int MEM_IDX_W      = $clog2(DEF_MEM_WORDS);

endpackage

// File: rtl/line_resp_sram.sv
// Synchronous read-first word RAM: one write port, one read port, 1-cycle
// read latency; the read register clears on reset, the array does not.
module line_resp_sram
  import refill_pkg::*;
#(
  parameter int DEPTH  = DEF_MEM_WORDS,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Array write; writes are honoured even while rst is low.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read register: holds its value while re is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/line_refill_responder.sv
// Memory-side end of the icache refill interface: one line address in,
// LINE_WORDS beats out. Define LINE_REFILL_WRAP_EN for critical-word-first order.
module line_refill_responder
  import refill_pkg::*;
#(
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int MEM_WORDS  = DEF_MEM_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic        s_rvalid,
  output logic        s_rlast,
  input  logic        s_rready,
  input  logic        pl_we,
  input  logic [31:0] pl_addr,
  input  logic [31:0] pl_wdata
);

  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int LINE_W = IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

  refill_state_e     state_r, state_nxt_s;
  logic [LINE_W-1:0] line_r, line_nxt_s;
  logic [OFF_W-1:0]  beat_r, beat_nxt_s;
  logic              arready_r, arready_nxt_s;
  logic              rvalid_r, rvalid_nxt_s;
  logic              rlast_r, rlast_nxt_s;
  logic              ar_hs_s, r_hs_s;
  logic              rd_en_s;
  logic [OFF_W-1:0]  rd_beat_s, rd_off_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic              unused_s;

  assign ar_hs_s  = s_arvalid & arready_r;
  assign r_hs_s   = rvalid_r & s_rready;
  assign rd_idx_s = {line_r, rd_off_s};

`ifdef LINE_REFILL_WRAP_EN
  logic [OFF_W-1:0] start_r, start_nxt_s;
  // Offset arithmetic wraps inside the line by width truncation.
  assign rd_off_s = rd_beat_s + start_r;
  assign unused_s = ^{s_araddr[31:IDX_W+2], s_araddr[1:0],
                      pl_addr[31:IDX_W+2], pl_addr[1:0]};
`else
  assign rd_off_s = rd_beat_s;
  assign unused_s = ^{s_araddr[31:IDX_W+2], s_araddr[OFF_W+1:0],
                      pl_addr[31:IDX_W+2], pl_addr[1:0]};
`endif

  // Next-state, read request and next registered-output values.
  always_comb begin
    state_nxt_s   = state_r;
    line_nxt_s    = line_r;
    beat_nxt_s    = beat_r;
    arready_nxt_s = 1'b0;
    rvalid_nxt_s  = rvalid_r;
    rlast_nxt_s   = rlast_r;
    rd_en_s       = 1'b0;
    rd_beat_s     = beat_r + OFF_W'(1'b1);
`ifdef LINE_REFILL_WRAP_EN
    start_nxt_s   = start_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (ar_hs_s) begin
          state_nxt_s = ST_FETCH;
          line_nxt_s  = s_araddr[IDX_W+1:OFF_W+2];
          beat_nxt_s  = {OFF_W{1'b0}};
`ifdef LINE_REFILL_WRAP_EN
          start_nxt_s = s_araddr[OFF_W+1:2];
`endif
        end else begin
          arready_nxt_s = 1'b1;
        end
      end
      ST_FETCH: begin
        rd_en_s      = 1'b1;
        rd_beat_s    = {OFF_W{1'b0}};
        state_nxt_s  = ST_SEND;
        rvalid_nxt_s = 1'b1;
        rlast_nxt_s  = 1'b0;
      end
      ST_SEND: begin
        if (r_hs_s && rlast_r) begin
          state_nxt_s   = ST_IDLE;
          rvalid_nxt_s  = 1'b0;
          rlast_nxt_s   = 1'b0;
          arready_nxt_s = 1'b1;
          beat_nxt_s    = {OFF_W{1'b0}};
        end else if (r_hs_s) begin
          rd_en_s     = 1'b1;
          beat_nxt_s  = rd_beat_s;
          rlast_nxt_s = (rd_beat_s == LAST_BEAT);
        end else begin
          rd_en_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        rvalid_nxt_s = 1'b0;
        rlast_nxt_s  = 1'b0;
      end
    endcase
  end

  // State and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      line_r    <= {LINE_W{1'b0}};
      beat_r    <= {OFF_W{1'b0}};
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
`ifdef LINE_REFILL_WRAP_EN
      start_r   <= {OFF_W{1'b0}};
`endif
    end else begin
      state_r   <= state_nxt_s;
      line_r    <= line_nxt_s;
      beat_r    <= beat_nxt_s;
      arready_r <= arready_nxt_s;
      rvalid_r  <= rvalid_nxt_s;
      rlast_r   <= rlast_nxt_s;
`ifdef LINE_REFILL_WRAP_EN
      start_r   <= start_nxt_s;
`endif
    end
  end

  line_resp_sram #(
    .DEPTH  (MEM_WORDS),
    .ADDR_W (IDX_W)
  ) u_sram (
    .clk   (clk),
    .rst   (rst),
    .we    (pl_we),
    .waddr (pl_addr[IDX_W+1:2]),
    .wdata (pl_wdata),
    .re    (rd_en_s),
    .raddr (rd_idx_s),
    .rdata (s_rdata)
  );

  assign s_arready = arready_r;
  assign s_rvalid  = rvalid_r;
  assign s_rlast   = rlast_r;

endmodule
